// File: rtl/capture_ctrl_pkg.sv
// capture_defs: shared definitions for the capture sequencer.
//   - ctrl_state_e : FSM state encodings, also exported on state_o
//   - STATE_W      : width of the state code
//   - DEF_TIMEOUT  : default ALIGN+LOCK cycle budget before a forced retry
//   - DEF_MAX_RETRY: default number of retries before FAULT
// The default constants are shared with the register map.
package capture_defs;

  localparam int STATE_W       = 3;
  localparam int DEF_TIMEOUT   = 3000;
  localparam int DEF_MAX_RETRY = 5;

  typedef enum logic [STATE_W-1:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_ALIGN = 3'd1,
    CTRL_LOCK  = 3'd2,
    CTRL_RUN   = 3'd3,
    CTRL_RETRY = 3'd4,
    CTRL_FAULT = 3'd5
  } ctrl_state_e;

  // The timeout budget covers ALIGN and LOCK together.
  function automatic logic in_align_window(input ctrl_state_e s);
    return (s == CTRL_ALIGN) || (s == CTRL_LOCK);
  endfunction

endpackage

// File: rtl/capture_ctrl_timeout.sv
// capture_timeout: alignment-timeout counter.
//   clk      - clock
//   rst_n    - asynchronous active-low reset, count -> 0
//   clear    - synchronous clear (loads 0), has priority over enable
//   enable   - count up by one per cycle
//   terminal - high while the count equals TIMEOUT-1
// The count stops at TIMEOUT-1, so it can never wrap while the FSM is
// still inside the ALIGN/LOCK window.
module capture_timeout #(
  parameter int TBITS   = 12,
  parameter int TIMEOUT = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [TBITS-1:0] LAST_COUNT = TBITS'(TIMEOUT - 1);

  logic [TBITS-1:0] count_reg;

  assign terminal = (count_reg == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencer for the multi-channel capture/alignment datapath.
//   clock_i     - oversampling clock (shared with the datapath)
//   reset_ni    - asynchronous active-low reset
//   enable_i    - capture requested (level)
//   lockeds_i   - per-channel locked flags
//   invalids_i  - per-channel invalid flags
//   valid_i     - aligned data valid
//   error_i     - aggregate tracking-lost flag
//   align_o     - datapath align request
//   clear_o     - one-cycle error-clear pulse (on RETRY)
//   acks_o      - one-cycle per-channel retry pulses (on RETRY)
//   running_o   - capture running and valid
//   fault_o     - retries exhausted
//   state_o     - current state code
//   retries_o   - completed RETRY visits since last IDLE
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state register.
module capture_ctrl
  import capture_defs::*;
#(
  parameter int WIDTH     = 24,
  parameter int MSB       = WIDTH - 1,
  parameter int TBITS     = 12,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int RBITS     = 3,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic [MSB:0]       lockeds_i,
  input  logic [MSB:0]       invalids_i,
  input  logic               valid_i,
  input  logic               error_i,
  output logic               align_o,
  output logic               clear_o,
  output logic [MSB:0]       acks_o,
  output logic               running_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o,
  output logic [RBITS-1:0]   retries_o
);

  localparam logic [RBITS-1:0] RETRY_LIMIT = RBITS'(MAX_RETRY);

  ctrl_state_e      state_reg, state_next;
  logic [RBITS-1:0] retries_reg, retries_next;
  logic             align_reg, clear_reg, running_reg, fault_reg;
  logic [MSB:0]     acks_reg;

  logic             all_locked;
  logic             timer_tc;
  logic             timer_run;
  logic [MSB:0]     fault_mask;
  logic [MSB:0]     ack_mask;

  assign all_locked = &lockeds_i;
  assign fault_mask = invalids_i | ~lockeds_i;
  // With no specific culprit (e.g. aggregate error or plain timeout while
  // locked), every channel is told to retry.
  assign ack_mask   = (fault_mask == '0) ? '1 : fault_mask;

  // The timer only keeps counting while staying inside ALIGN/LOCK; any
  // entry into the window starts it from zero.
  assign timer_run  = in_align_window(state_reg) && in_align_window(state_next);

  capture_timeout #(
    .TBITS   (TBITS),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clock_i),
    .rst_n    (reset_ni),
    .clear    (!timer_run),
    .enable   (timer_run),
    .terminal (timer_tc)
  );

  always_comb begin
    state_next = state_reg;
    if (!enable_i) begin
      state_next = CTRL_IDLE;
    end else begin
      case (state_reg)
        CTRL_IDLE:  state_next = CTRL_ALIGN;
        CTRL_ALIGN: begin
          if (all_locked)    state_next = CTRL_LOCK;
          else if (timer_tc) state_next = CTRL_RETRY;
        end
        CTRL_LOCK: begin
          // valid_i beats a simultaneous timeout
          if (valid_i)                       state_next = CTRL_RUN;
          else if (!all_locked || timer_tc)  state_next = CTRL_RETRY;
        end
        CTRL_RUN: begin
          if (error_i || (|invalids_i)) state_next = CTRL_RETRY;
        end
        CTRL_RETRY: begin
          if (retries_reg == RETRY_LIMIT) state_next = CTRL_FAULT;
          else                            state_next = CTRL_ALIGN;
        end
        CTRL_FAULT: state_next = CTRL_FAULT;
        default:    state_next = CTRL_IDLE;
      endcase
    end
  end

  // Increment only on RETRY -> ALIGN, which never happens at the limit,
  // so the counter saturates at MAX_RETRY without an explicit clamp.
  always_comb begin
    retries_next = retries_reg;
    if (state_next == CTRL_IDLE) begin
      retries_next = '0;
    end else if (state_reg == CTRL_RETRY && state_next == CTRL_ALIGN) begin
      retries_next = retries_reg + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg   <= CTRL_IDLE;
      retries_reg <= '0;
      align_reg   <= 1'b0;
      clear_reg   <= 1'b0;
      acks_reg    <= '0;
      running_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      retries_reg <= retries_next;
      align_reg   <= (state_next == CTRL_ALIGN) || (state_next == CTRL_LOCK) ||
                     (state_next == CTRL_RUN);
      clear_reg   <= (state_next == CTRL_RETRY);
      acks_reg    <= (state_next == CTRL_RETRY) ? ack_mask : '0;
      // running asserts from the second RUN cycle and drops on the edge
      // that leaves RUN.
      running_reg <= (state_reg == CTRL_RUN) && (state_next == CTRL_RUN);
      fault_reg   <= (state_next == CTRL_FAULT);
    end
  end

  assign state_o   = state_reg;
  assign retries_o = retries_reg;
  assign align_o   = align_reg;
  assign clear_o   = clear_reg;
  assign acks_o    = acks_reg;
  assign running_o = running_reg;
  assign fault_o   = fault_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with a short timeout
// (TIMEOUT=16) and retry budget (MAX_RETRY=2).
module tb_capture_ctrl;

  localparam int WIDTH     = 24;
  localparam int TBITS     = 12;
  localparam int TIMEOUT   = 16;
  localparam int RBITS     = 3;
  localparam int MAX_RETRY = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             valid = 1'b0;
  logic             error = 1'b0;
  logic [WIDTH-1:0] lockeds = '0;
  logic [WIDTH-1:0] invalids = '0;

  logic             align, clear, running, fault;
  logic [WIDTH-1:0] acks;
  logic [2:0]       state;
  logic [RBITS-1:0] retries;

  int vectors = 0;
  int miscompares = 0;
  int clear_pulses = 0;

  capture_ctrl #(
    .WIDTH     (WIDTH),
    .MSB       (WIDTH - 1),
    .TBITS     (TBITS),
    .TIMEOUT   (TIMEOUT),
    .RBITS     (RBITS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .enable_i   (enable),
    .lockeds_i  (lockeds),
    .invalids_i (invalids),
    .valid_i    (valid),
    .error_i    (error),
    .align_o    (align),
    .clear_o    (clear),
    .acks_o     (acks),
    .running_o  (running),
    .fault_o    (fault),
    .state_o    (state),
    .retries_o  (retries)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clear) clear_pulses++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int st, input bit al, input bit cl,
                            input logic [WIDTH-1:0] ak, input bit rn, input bit fl, input int rt);
    check_value({tag, ".state"},   32'(state),   32'(st));
    check_value({tag, ".align"},   32'(align),   32'(al));
    check_value({tag, ".clear"},   32'(clear),   32'(cl));
    check_value({tag, ".acks"},    32'(acks),    32'(ak));
    check_value({tag, ".running"}, 32'(running), 32'(rn));
    check_value({tag, ".fault"},   32'(fault),   32'(fl));
    check_value({tag, ".retries"}, 32'(retries), 32'(rt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int visits;

    // Reset state
    step(3);
    expect_all("reset", 0, 0, 0, '0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1);
    check_value("idle_no_enable", 32'(state), 32'd0);

    // Bring-up: ALIGN -> LOCK -> RUN
    enable = 1'b1;
    step(1);
    expect_all("bringup.align", 1, 1, 0, '0, 0, 0, 0);
    step(3);
    check_value("bringup.align_hold", 32'(state), 32'd1);
    lockeds = '1;
    step(1);
    expect_all("bringup.lock", 2, 1, 0, '0, 0, 0, 0);
    step(3);
    valid = 1'b1;
    step(1);
    expect_all("bringup.run_entry", 3, 1, 0, '0, 0, 0, 0);
    step(1);
    check_value("bringup.running", 32'(running), 32'd1);
    check_value("bringup.no_clear", 32'(clear_pulses), 32'd0);
    valid = 1'b0;

    // Aggregate error in RUN: no culprit, so all channels acked
    error = 1'b1;
    step(1);
    error = 1'b0;
    expect_all("err.retry", 4, 0, 1, 24'hFFFFFF, 0, 0, 0);
    step(1);
    expect_all("err.realign", 1, 1, 0, '0, 0, 0, 1);
    valid = 1'b1;
    step(1);
    check_value("err.lock", 32'(state), 32'd2);
    step(1);
    check_value("err.run", 32'(state), 32'd3);
    step(1);
    check_value("err.running", 32'(running), 32'd1);
    valid = 1'b0;

    // Run-time loss on channel 4
    invalids = 24'h000010;
    step(1);
    invalids = '0;
    expect_all("loss.retry", 4, 0, 1, 24'h000010, 0, 0, 1);
    step(1);
    expect_all("loss.realign", 1, 1, 0, '0, 0, 0, 2);
    enable = 1'b0;
    step(1);
    expect_all("loss.idle", 0, 0, 0, '0, 0, 0, 0);

    // Tie-break: valid on the timeout cycle in LOCK wins
    enable = 1'b1;
    lockeds = '1;
    step(1);
    check_value("tie.align", 32'(state), 32'd1);
    step(1);
    check_value("tie.lock", 32'(state), 32'd2);
    step(14);
    check_value("tie.lock_hold", 32'(state), 32'd2);
    valid = 1'b1;
    step(1);
    check_value("tie.run", 32'(state), 32'd3);
    check_value("tie.no_clear", 32'(clear), 32'd0);
    valid = 1'b0;
    enable = 1'b0;
    step(1);
    check_value("tie.idle", 32'(state), 32'd0);

    // LOCK timeout while fully locked -> all-ones acks; abort the RETRY
    enable = 1'b1;
    step(2);
    check_value("locktmo.lock", 32'(state), 32'd2);
    step(14);
    check_value("locktmo.lock_hold", 32'(state), 32'd2);
    step(1);
    expect_all("locktmo.retry", 4, 0, 1, 24'hFFFFFF, 0, 0, 0);
    enable = 1'b0;
    step(1);
    expect_all("abort.idle", 0, 0, 0, '0, 0, 0, 0);

    // ALIGN timeout with channel 23 never locking
    lockeds = 24'h7FFFFF;
    enable = 1'b1;
    c0 = clear_pulses;
    step(1);
    check_value("timeout.align", 32'(state), 32'd1);
    step(15);
    check_value("timeout.align16", 32'(state), 32'd1);
    step(1);
    expect_all("timeout.retry", 4, 0, 1, 24'h800000, 0, 0, 0);
    step(1);
    expect_all("timeout.realign", 1, 1, 0, '0, 0, 0, 1);
    check_value("timeout.clear_once", 32'(clear_pulses - c0), 32'd1);

    // Exhaustion: keep timing out until FAULT
    visits = 1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (state == 3'd4) visits++;
      if (state == 3'd5) break;
    end
    check_value("exhaust.visits", 32'(visits), 32'd3);
    expect_all("exhaust.fault", 5, 0, 0, '0, 0, 1, 2);
    lockeds = '1;
    valid = 1'b1;
    step(5);
    expect_all("exhaust.hold", 5, 0, 0, '0, 0, 1, 2);
    valid = 1'b0;
    enable = 1'b0;
    step(1);
    expect_all("exhaust.idle", 0, 0, 0, '0, 0, 0, 0);

    // Asynchronous reset in the middle of RUN
    enable = 1'b1;
    valid = 1'b1;
    step(3);
    check_value("arst.run", 32'(state), 32'd3);
    step(1);
    check_value("arst.running", 32'(running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("arst.immediate", 0, 0, 0, '0, 0, 0, 0);
    enable = 1'b0;
    valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1);
    check_value("arst.idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
